rf_2r_1w_param: RTL and testbench

- Parametrised register file: two asynchronous read ports, one synchronous write port.
- Successor to the fixed 32x32 single-read-port register file.
- Adds:
  - configurable width and depth
  - hardware clear after reset, done by a walking state machine
  - optional write-to-read bypass
  - defined handling of out-of-range addresses
- Sits in the GIP core as the architectural and scratch register store; feeds the ALU operand muxes directly.

---
 rtl/rf_2r_1w_param.sv | 115 +++++++++++
 tb/tb_rf_2r_1w_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rf_2r_1w_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port.
// After reset a walking clear zeroes every entry; reads return 0 until it finishes.
module rf_2r_1w_param #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DEPTH       = 32,
  parameter bit          READ_BYPASS = 1'b1
) (
  input  logic                  rf_clock,
  input  logic                  rf_reset,
  input  logic [ADDR_WIDTH-1:0] rf_rd_addr_0,
  output logic [DATA_WIDTH-1:0] rf_rd_data_0,
  input  logic [ADDR_WIDTH-1:0] rf_rd_addr_1,
  output logic [DATA_WIDTH-1:0] rf_rd_data_1,
  input  logic                  rf_wr_enable,
  input  logic [ADDR_WIDTH-1:0] rf_wr_addr,
  input  logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_busy
);

  localparam int unsigned           IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we;
  logic [IDX_W-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [ADDR_WIDTH-1:0]   rd_addr [2];
  logic [DATA_WIDTH-1:0]   rd_data [2];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  assign rf_busy = (state_q == ST_CLEAR);

  // Single storage write path: reset zeroes entry 0, the clear walk zeroes the rest,
  // and user writes only land once the walk has finished.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    if (rf_reset) begin
      mem_we = 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = clr_addr_q[IDX_W-1:0];
          if (clr_addr_q == LAST_ADDR) begin
            state_d = ST_READY;
          end else begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
          end
        end
        ST_READY: begin
          if (rf_wr_enable && in_range(rf_wr_addr)) begin
            mem_we    = 1'b1;
            mem_waddr = rf_wr_addr[IDX_W-1:0];
            mem_wdata = rf_wr_data;
          end
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge rf_clock) begin
    if (rf_reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_ff @(posedge rf_clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_addr[0] = rf_rd_addr_0;
  assign rd_addr[1] = rf_rd_addr_1;

  // Busy and out-of-range reads are forced to zero so no stale or X data escapes.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if (state_q == ST_READY && in_range(rd_addr[p])) begin
        if (READ_BYPASS && rf_wr_enable && (rf_wr_addr == rd_addr[p])) begin
          rd_data[p] = rf_wr_data;
        end else begin
          rd_data[p] = mem_q[rd_addr[p][IDX_W-1:0]];
        end
      end
    end
  end

  assign rf_rd_data_0 = rd_data[0];
  assign rf_rd_data_1 = rd_data[1];

endmodule

// File: tb/tb_rf_2r_1w_param.sv
// Directed bench for rf_2r_1w_param: three instances (default, no bypass, DEPTH=24)
// share one stimulus stream and each output is checked against hand-computed values.
module tb_rf_2r_1w_param;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra0;
  logic [4:0]  ra1;

  logic [31:0] mainRd0, mainRd1, nbRd0, nbRd1, oorRd0, oorRd1;
  logic        mainBusy, nbBusy, oorBusy;

  int checks;
  int failures;
  int mainCnt;
  int oorCnt;

  rf_2r_1w_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .READ_BYPASS(1'b1)) u_main (
    .rf_clock(clk), .rf_reset(reset),
    .rf_rd_addr_0(ra0), .rf_rd_data_0(mainRd0),
    .rf_rd_addr_1(ra1), .rf_rd_data_1(mainRd1),
    .rf_wr_enable(we), .rf_wr_addr(waddr), .rf_wr_data(wdata),
    .rf_busy(mainBusy)
  );

  rf_2r_1w_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .READ_BYPASS(1'b0)) u_nb (
    .rf_clock(clk), .rf_reset(reset),
    .rf_rd_addr_0(ra0), .rf_rd_data_0(nbRd0),
    .rf_rd_addr_1(ra1), .rf_rd_data_1(nbRd1),
    .rf_wr_enable(we), .rf_wr_addr(waddr), .rf_wr_data(wdata),
    .rf_busy(nbBusy)
  );

  rf_2r_1w_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(24), .READ_BYPASS(1'b1)) u_oor (
    .rf_clock(clk), .rf_reset(reset),
    .rf_rd_addr_0(ra0), .rf_rd_data_0(oorRd0),
    .rf_rd_addr_1(ra1), .rf_rd_data_1(oorRd1),
    .rf_wr_enable(we), .rf_wr_addr(waddr), .rf_wr_data(wdata),
    .rf_busy(oorBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wEn, input logic [4:0] wAddr, input logic [31:0] wData,
                               input logic [4:0] rAddr0, input logic [4:0] rAddr1);
    we    = wEn;
    waddr = wAddr;
    wdata = wData;
    ra0   = rAddr0;
    ra1   = rAddr1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Counts cycles until the default instance leaves the clear walk; also notes
  // the cycle on which the 24-entry instance finished. Bounded at 100 cycles.
  task automatic waitClear(output int mCnt, output int oCnt);
    mCnt = 0;
    oCnt = -1;
    while (mainBusy === 1'b1 && mCnt < 100) begin
      nextCycle();
      mCnt++;
      if (oCnt < 0 && oorBusy !== 1'b1) oCnt = mCnt;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd17);
    repeat (3) nextCycle();
    checkOutput("busy_in_reset", {31'b0, mainBusy}, 32'd1);
    checkOutput("rd_in_reset", mainRd0, 32'h0);

    // Release reset while hammering addr 3 with writes that must be dropped.
    reset = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd3);
    #1;
    checkOutput("rd_while_busy", mainRd0, 32'h0);
    waitClear(mainCnt, oorCnt);
    checkOutput("clear_len", 32'(mainCnt), 32'd32);
    checkOutput("oor_clear_len", 32'(oorCnt), 32'd24);
    checkOutput("nb_busy_done", {31'b0, nbBusy}, 32'd0);

    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd17);
    #1;
    checkOutput("clr_rd0_a0", mainRd0, 32'h0);
    checkOutput("clr_rd1_a17", mainRd1, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    #1;
    checkOutput("clr_rd0_a31", mainRd0, 32'h0);
    checkOutput("clr_rd1_a31", mainRd1, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    #1;
    checkOutput("busy_write_dropped", mainRd0, 32'h0);
    checkOutput("nb_busy_write_dropped", nbRd1, 32'h0);
    checkOutput("oor_late_write_landed", oorRd0, 32'hFFFFFFFF);

    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd31, 32'h12345678, 5'd0, 5'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    #1;
    checkOutput("wr_rd0_a5", mainRd0, 32'hDEADBEEF);
    checkOutput("wr_rd1_a31", mainRd1, 32'h12345678);
    checkOutput("nb_wr_rd1_a31", nbRd1, 32'h12345678);
    checkOutput("oor_wr_rd1_a31", oorRd1, 32'h0);

    applyStimulus(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
    #1;
    checkOutput("bypass_rd0", mainRd0, 32'hA5A5A5A5);
    checkOutput("bypass_rd1", mainRd1, 32'hA5A5A5A5);
    checkOutput("nb_old_value", nbRd0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    checkOutput("nb_next_cycle", nbRd0, 32'hA5A5A5A5);

    applyStimulus(1'b1, 5'd28, 32'h77, 5'd28, 5'd4);
    #1;
    checkOutput("oor_bypass_blocked", oorRd0, 32'h0);
    checkOutput("main_bypass_a28", mainRd0, 32'h77);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd28, 5'd4);
    #1;
    checkOutput("oor_rd_a28", oorRd0, 32'h0);
    checkOutput("oor_alias_a4", oorRd1, 32'h0);
    checkOutput("main_rd_a28", mainRd0, 32'h77);

    applyStimulus(1'b1, 5'd20, 32'h55, 5'd0, 5'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd20, 5'd20);
    #1;
    checkOutput("pre_reset_a20", mainRd0, 32'h55);
    checkOutput("oor_pre_reset_a20", oorRd1, 32'h55);

    // Reset from READY, then a second reset ten cycles into the clear walk.
    reset = 1'b1;
    nextCycle();
    checkOutput("busy_after_ready_reset", {31'b0, mainBusy}, 32'd1);
    reset = 1'b0;
    repeat (10) nextCycle();
    checkOutput("busy_mid_clear", {31'b0, mainBusy}, 32'd1);
    checkOutput("rd_mid_clear_a20", mainRd0, 32'h0);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    waitClear(mainCnt, oorCnt);
    checkOutput("restart_clear_len", 32'(mainCnt), 32'd32);
    checkOutput("oor_restart_clear_len", 32'(oorCnt), 32'd24);
    checkOutput("recleared_a20", mainRd0, 32'h0);
    checkOutput("nb_recleared_a20", nbRd1, 32'h0);
    checkOutput("oor_recleared_a20", oorRd0, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
    #1;
    checkOutput("recleared_a5", mainRd0, 32'h0);
    checkOutput("recleared_a9", mainRd1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
